ft_bus_scheduler: RTL and testbench
===================================

// Module: ft_bus_scheduler
// PURPOSE
//  Fair half-duplex scheduler for the FT600/FT601 synchronous FIFO bus, in the ft_clk domain.
//  Sits between the FT pins and the TX/RX async FIFOs:
//   - arbitrates read vs write bursts;
//   - enforces per-direction burst limits and bus turnaround;
//   - produces ft_oe/ft_rd/ft_wr and the FIFO get/put strobes.
//  Replaces fixed-priority sequencing so that one direction cannot starve the other.
// PARAMETERS
//  RD_BURST_MAX  256  max RX words per read burst (>=1)
//  WR_BURST_MAX  256  max TX words per write burst (>=1)
//  TURNAROUND    1    cycles with ft_oe=0, ft_rd=1 before a read burst (>=1)
//  PRIORITY_TX   0    default winner when both directions are ready (0=RX, 1=TX)
// PORTS
//  ft_clk     in   1  FTDI clock; all logic on rising edge
//  rst        in   1  reset, asynchronous, active-high
//  en         in   1  1 = scheduling allowed; 0 = drain to idle
//  ft_rxf     in   1  0 = FTDI has RX data
//  ft_txe     in   1  0 = FTDI can accept TX data
//  tx_empty   in   1  TX FIFO read-side empty
//  rx_full    in   1  RX FIFO write-side full
//  ft_oe      out  1  0 = FTDI drives bus
//  ft_rd      out  1  0 = read strobe
//  ft_wr      out  1  0 = write strobe
//  tx_get     out  1  pop TX FIFO this cycle
//  rx_put     out  1  push ft_data/ft_be into RX FIFO this cycle
//  rd_active  out  1  state is BUS_SWITCH or READ
//  wr_active  out  1  state is WRITE
// BEHAVIOUR
//  Reset values (state IDLE): ft_oe=1, ft_rd=1, ft_wr=1, tx_get=0, rx_put=0, rd_active=0, wr_active=0.
//  Reset also sets prio=PRIORITY_TX and burst_cnt=0. Reset mid-burst aborts the burst the same cycle.
//  State/registers: state, burst_cnt, turn_cnt, prio.
//  Outputs are Mealy-decoded from the registered state and the live inputs.
//  can_rd = en & ~ft_rxf & ~rx_full;  can_wr = en & ~ft_txe & ~tx_empty.
//  IDLE:
//   - outputs at default values.
//   - can_rd only -> BUS_SWITCH; can_wr only -> WRITE.
//   - both -> direction given by prio (1 = WRITE).
//   - neither, or en=0 -> stay in IDLE.
//   - entering BUS_SWITCH or WRITE clears burst_cnt and turn_cnt.
//  BUS_SWITCH:
//   - ft_oe=0, ft_rd=1, rx_put=0.
//   - stays TURNAROUND cycles, then -> READ unconditionally.
//   - a late ft_rxf rise is handled in READ.
//  READ:
//   - ft_oe = rx_full; ft_rd = rx_full | ft_rxf; rx_put = ~ft_rxf & ~rx_full.
//   - each rx_put increments burst_cnt.
//   - exit to IDLE when ~can_rd.
//   - also exit to IDLE on an rx_put that makes burst_cnt reach RD_BURST_MAX.
//     That word is still transferred.
//  WRITE:
//   - ft_oe=1; ft_wr = tx_empty; tx_get = ~ft_txe & ~tx_empty.
//   - each tx_get increments burst_cnt.
//   - exit to IDLE when ~can_wr, or on the tx_get that reaches WR_BURST_MAX.
//  Fairness (prio update, on exit only):
//   - burst-limit exit -> prio set to the opposite direction.
//   - other exits (source dry, sink full, en=0) -> prio = PRIORITY_TX.
//  IDLE always lasts >=1 cycle between bursts; this guarantees ft_oe=1 bus release after a read.
//  No direct READ->WRITE or WRITE->READ transition exists.
//  Illegal state encoding -> IDLE.
//  ft_oe=0 is never asserted in IDLE or WRITE, so the FPGA and the FTDI never drive the bus together.
//  Counter width = $clog2(max(RD_BURST_MAX, WR_BURST_MAX) + 1); burst_cnt never wraps.
// STRUCTURE
//  Shared package ft_pkg holds:
//   - state typedef ft_sched_state_t: IDLE, BUS_SWITCH, READ, WRITE.
//   - localparams for FT bus widths and the active-low strobe levels.
//  No sub-module: counters and the FSM stay flat in this file.
//  ft instantiates this block in place of its internal FSM.
// TESTING
//  1. RD_BURST_MAX=4, ft_rxf=0 held, rx_full=0 -> per read burst:
//     - 1 BUS_SWITCH cycle, then exactly 4 rx_put pulses, then 1 IDLE cycle with ft_oe=1;
//     - the sequence repeats.
//  2. Both ready, WR/RD_BURST_MAX=8, PRIORITY_TX=0 -> RX 8 words, then TX 8 words, alternating.
//     No burst exceeds 8 words and none is skipped.
//  3. In READ, ft_rxf rises after 3 words -> rx_put=0 and ft_rd=1 that cycle; next state IDLE.
//     prio returns to PRIORITY_TX.
//  4. In WRITE, tx_empty rises mid-burst -> ft_wr=1 and tx_get=0 the same cycle; next state IDLE.
//     No spurious pop occurs.
//  5. TURNAROUND=3 -> ft_oe=0 and ft_rd=1 for exactly 3 cycles before the first rx_put.
//     Check that ft_rxf toggling during turnaround does not break this.
//  6. rst asserted mid-WRITE, and en=0 mid-READ:
//     - rst -> outputs return to reset values immediately;
//     - en=0 -> burst ends next cycle, FSM holds IDLE while en=0.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared FT600/FT601 bus definitions: scheduler state encoding, FT bus widths
// and the levels used for the active-low FT control strobes.
package ft_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUS_SWITCH = 2'd1,
        READ       = 2'd2,
        WRITE      = 2'd3
    } ft_sched_state_t;

    localparam int FT_DATA_W = 32;
    localparam int FT_BE_W   = 4;

    // FT strobes (ft_oe/ft_rd/ft_wr) are active-low
    localparam logic FT_ASSERT   = 1'b0;
    localparam logic FT_DEASSERT = 1'b1;

endpackage : ft_pkg

// File: rtl/ft_bus_scheduler.sv
// Fair half-duplex scheduler for the FT600/FT601 synchronous FIFO bus.
// Arbitrates read vs write bursts, bounds each burst, inserts the read
// turnaround and produces the FT strobes plus the FIFO get/put strobes.
// Outputs are Mealy-decoded from the registered state and the live inputs.
module ft_bus_scheduler
    import ft_pkg::*;
#(
    parameter int RD_BURST_MAX = 256,
    parameter int WR_BURST_MAX = 256,
    parameter int TURNAROUND   = 1,
    parameter bit PRIORITY_TX  = 1'b0
) (
    input  logic ft_clk,
    input  logic rst,
    input  logic en,
    input  logic ft_rxf,
    input  logic ft_txe,
    input  logic tx_empty,
    input  logic rx_full,
    output logic ft_oe,
    output logic ft_rd,
    output logic ft_wr,
    output logic tx_get,
    output logic rx_put,
    output logic rd_active,
    output logic wr_active
);

    localparam int BURST_MAX = (RD_BURST_MAX > WR_BURST_MAX) ? RD_BURST_MAX : WR_BURST_MAX;
    localparam int CNT_W     = $clog2(BURST_MAX + 1);
    localparam int TURN_W    = $clog2(TURNAROUND + 1);

    localparam logic [CNT_W-1:0]  RD_LAST   = CNT_W'(RD_BURST_MAX - 1);
    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(WR_BURST_MAX - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

    ft_sched_state_t   state, state_n;
    logic [CNT_W-1:0]  burst_cnt, burst_cnt_n;
    logic [TURN_W-1:0] turn_cnt, turn_cnt_n;
    logic              prio, prio_n;   // 1 = TX wins when both sides are ready

    logic can_rd;
    logic can_wr;

    assign can_rd = en & ~ft_rxf & ~rx_full;
    assign can_wr = en & ~ft_txe & ~tx_empty;

    // State and counter registers; reset aborts any burst immediately
    always_ff @(posedge ft_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            turn_cnt  <= '0;
            prio      <= PRIORITY_TX;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state     <= state_n;
            burst_cnt <= burst_cnt_n;
            turn_cnt  <= turn_cnt_n;
            prio      <= prio_n;
        end
    end

    // Next-state, counter/priority update and Mealy output decode
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_n     = state;
        burst_cnt_n = burst_cnt;
        turn_cnt_n  = turn_cnt;
        prio_n      = prio;
        ft_oe       = FT_DEASSERT;
        ft_rd       = FT_DEASSERT;
        ft_wr       = FT_DEASSERT;
        tx_get      = 1'b0;
        rx_put      = 1'b0;
        rd_active   = 1'b0;
        wr_active   = 1'b0;

        unique case (state)
            IDLE: begin
                if (can_rd && (!can_wr || !prio)) begin
                    state_n     = BUS_SWITCH;
                    burst_cnt_n = '0;
                    turn_cnt_n  = '0;
                end else if (can_wr) begin
                    state_n     = WRITE;
                    burst_cnt_n = '0;
                    turn_cnt_n  = '0;
                end
            end

            BUS_SWITCH: begin
                // FPGA releases the bus; FTDI gets TURNAROUND cycles to drive it
                ft_oe     = FT_ASSERT;
                rd_active = 1'b1;
                if (turn_cnt == TURN_LAST) begin
                    state_n = READ;
                end else begin
                    turn_cnt_n = turn_cnt + 1'b1;
                end
            end

            READ: begin
                rd_active = 1'b1;
                ft_oe     = rx_full;
                ft_rd     = rx_full | ft_rxf;
                rx_put    = ~ft_rxf & ~rx_full;
                if (rx_put) begin
                    burst_cnt_n = burst_cnt + 1'b1;
                end
                // Burst limit wins: the last word is transferred, then TX gets a turn
                if (rx_put && burst_cnt == RD_LAST) begin
                    state_n = IDLE;
                    prio_n  = 1'b1;
                end else if (!can_rd) begin
                    state_n = IDLE;
                    prio_n  = PRIORITY_TX;
                end
            end

            WRITE: begin
                wr_active = 1'b1;
                ft_wr     = tx_empty;
                tx_get    = ~ft_txe & ~tx_empty;
                if (tx_get) begin
                    burst_cnt_n = burst_cnt + 1'b1;
                end
                if (tx_get && burst_cnt == WR_LAST) begin
                    state_n = IDLE;
                    prio_n  = 1'b0;
                end else if (!can_wr) begin
                    state_n = IDLE;
                    prio_n  = PRIORITY_TX;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule : ft_bus_scheduler

// File: tb/tb_ft_bus_scheduler.sv
// Scoreboard bench for ft_bus_scheduler. Two instances share the stimulus:
// dut_a (bursts of 4, turnaround 1) and dut_b (bursts of 8, turnaround 3).
// Each directed vector drives inputs just after a rising edge and pushes the
// hand-computed expected outputs; a monitor pops and compares on the falling edge.
module tb_ft_bus_scheduler;

    // Expected output vectors {ft_oe, ft_rd, ft_wr, tx_get, rx_put, rd_active, wr_active}
    localparam logic [6:0] O_IDLE    = 7'b111_0000;
    localparam logic [6:0] O_SW      = 7'b011_0010;
    localparam logic [6:0] O_RD      = 7'b001_0110;
    localparam logic [6:0] O_RDSTOP  = 7'b011_0010;
    localparam logic [6:0] O_WR      = 7'b110_1001;
    localparam logic [6:0] O_WRSTOP  = 7'b111_0001;

    // Input vectors {en, ft_rxf, ft_txe, tx_empty, rx_full}
    localparam logic [4:0] IN_NONE   = 5'b1_1110;
    localparam logic [4:0] IN_RD     = 5'b1_0110;
    localparam logic [4:0] IN_WR     = 5'b1_1000;
    localparam logic [4:0] IN_BOTH   = 5'b1_0000;
    localparam logic [4:0] IN_WR_DRY = 5'b1_1010;
    localparam logic [4:0] IN_RD_OFF = 5'b0_0110;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef struct packed {
        logic       sel;
        logic [6:0] exp;
    } exp_t;

    logic ft_clk;
    logic rst;
    logic en, ft_rxf, ft_txe, tx_empty, rx_full;
    logic [6:0] out_a, out_b;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks;
    int    errors;

    ft_bus_scheduler #(
        .RD_BURST_MAX(4), .WR_BURST_MAX(4), .TURNAROUND(1), .PRIORITY_TX(1'b0)
    ) dut_a (
        .ft_clk(ft_clk), .rst(rst), .en(en), .ft_rxf(ft_rxf), .ft_txe(ft_txe),
        .tx_empty(tx_empty), .rx_full(rx_full),
        .ft_oe(out_a[6]), .ft_rd(out_a[5]), .ft_wr(out_a[4]), .tx_get(out_a[3]),
        .rx_put(out_a[2]), .rd_active(out_a[1]), .wr_active(out_a[0])
    );

    ft_bus_scheduler #(
        .RD_BURST_MAX(8), .WR_BURST_MAX(8), .TURNAROUND(3), .PRIORITY_TX(1'b0)
    ) dut_b (
        .ft_clk(ft_clk), .rst(rst), .en(en), .ft_rxf(ft_rxf), .ft_txe(ft_txe),
        .tx_empty(tx_empty), .rx_full(rx_full),
        .ft_oe(out_b[6]), .ft_rd(out_b[5]), .ft_wr(out_b[4]), .tx_get(out_b[3]),
        .rx_put(out_b[2]), .rd_active(out_b[1]), .wr_active(out_b[0])
    );

    initial begin
        ft_clk = 1'b0;
        forever #5 ft_clk = ~ft_clk;
    end

    task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got oe/rd/wr/get/put/ra/wa=%b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare the selected instance against the oldest expectation
    always @(negedge ft_clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, e.sel ? out_b : out_a, e.exp);
        end
    end

    // Drive one cycle of stimulus n times and queue the expected response each time
    task automatic vec(input logic sel, input logic r, input logic [4:0] iv,
                       input logic [6:0] ev, input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ft_clk);
            #1;
            rst = r;
            {en, ft_rxf, ft_txe, tx_empty, rx_full} = iv;
            exp_q.push_back('{sel: sel, exp: ev});
            name_q.push_back(nm);
        end
    endtask

    task automatic do_reset(input logic sel);
        vec(sel, 1'b1, IN_BOTH, O_IDLE, "reset_state", 2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        {en, ft_rxf, ft_txe, tx_empty, rx_full} = IN_NONE;

        // Read bursts of 4 repeat with a switch cycle before and an idle cycle after
        do_reset(SEL_A);
        for (int b = 0; b < 2; b++) begin
            vec(SEL_A, 1'b0, IN_RD, O_IDLE, "rd4_idle", 1);
            vec(SEL_A, 1'b0, IN_RD, O_SW,   "rd4_switch", 1);
            vec(SEL_A, 1'b0, IN_RD, O_RD,   "rd4_word", 4);
        end
        // ft_rxf rises after 3 words: no put that cycle, then IDLE, prio back to RX
        vec(SEL_A, 1'b0, IN_RD,   O_IDLE,   "rxf_idle", 1);
        vec(SEL_A, 1'b0, IN_RD,   O_SW,     "rxf_switch", 1);
        vec(SEL_A, 1'b0, IN_RD,   O_RD,     "rxf_word", 3);
        vec(SEL_A, 1'b0, IN_NONE, O_RDSTOP, "rxf_rise_stop", 1);
        vec(SEL_A, 1'b0, IN_NONE, O_IDLE,   "rxf_after_idle", 1);
        vec(SEL_A, 1'b0, IN_BOTH, O_IDLE,   "prio_idle", 1);
        vec(SEL_A, 1'b0, IN_BOTH, O_SW,     "prio_rx_wins", 1);

        // tx_empty rises mid-write: strobe and pop drop the same cycle
        do_reset(SEL_A);
        vec(SEL_A, 1'b0, IN_WR,     O_IDLE,   "wr_idle", 1);
        vec(SEL_A, 1'b0, IN_WR,     O_WR,     "wr_word", 2);
        vec(SEL_A, 1'b0, IN_WR_DRY, O_WRSTOP, "tx_empty_stop", 1);
        vec(SEL_A, 1'b0, IN_WR_DRY, O_IDLE,   "tx_empty_idle", 1);
        // Full write burst of 4, then the mandatory idle cycle
        vec(SEL_A, 1'b0, IN_WR,     O_IDLE,   "wr4_idle", 1);
        vec(SEL_A, 1'b0, IN_WR,     O_WR,     "wr4_word", 4);
        vec(SEL_A, 1'b0, IN_WR,     O_IDLE,   "wr4_after_idle", 1);
        vec(SEL_A, 1'b0, IN_WR,     O_WR,     "wr4_next_burst", 1);

        // Reset mid-write returns outputs to reset values at once
        vec(SEL_A, 1'b1, IN_WR, O_IDLE, "rst_mid_write", 1);
        vec(SEL_A, 1'b0, IN_NONE, O_IDLE, "rst_release", 1);

        // en=0 mid-read: word still moves this cycle, then IDLE held while en=0
        vec(SEL_A, 1'b0, IN_RD,     O_IDLE, "en_rd_idle", 1);
        vec(SEL_A, 1'b0, IN_RD,     O_SW,   "en_rd_switch", 1);
        vec(SEL_A, 1'b0, IN_RD,     O_RD,   "en_rd_word", 2);
        vec(SEL_A, 1'b0, IN_RD_OFF, O_RD,   "en_drop_last", 1);
        vec(SEL_A, 1'b0, IN_RD_OFF, O_IDLE, "en_low_hold", 3);

        // Both ready, bursts of 8: RX, TX, RX with 3-cycle turnaround
        do_reset(SEL_B);
        vec(SEL_B, 1'b0, IN_BOTH, O_IDLE, "fair_idle0", 1);
        vec(SEL_B, 1'b0, IN_BOTH, O_SW,   "fair_switch0", 3);
        vec(SEL_B, 1'b0, IN_BOTH, O_RD,   "fair_rx0", 8);
        vec(SEL_B, 1'b0, IN_BOTH, O_IDLE, "fair_idle1", 1);
        vec(SEL_B, 1'b0, IN_BOTH, O_WR,   "fair_tx1", 8);
        vec(SEL_B, 1'b0, IN_BOTH, O_IDLE, "fair_idle2", 1);
        vec(SEL_B, 1'b0, IN_BOTH, O_SW,   "fair_switch2", 3);
        vec(SEL_B, 1'b0, IN_BOTH, O_RD,   "fair_rx2", 8);
        vec(SEL_B, 1'b0, IN_NONE, O_IDLE, "fair_idle3", 1);

        // Turnaround of 3 is unaffected by ft_rxf toggling during it
        do_reset(SEL_B);
        vec(SEL_B, 1'b0, IN_RD,   O_IDLE,   "ta_idle", 1);
        vec(SEL_B, 1'b0, IN_RD,   O_SW,     "ta_switch1", 1);
        vec(SEL_B, 1'b0, IN_NONE, O_SW,     "ta_switch2_rxf_high", 1);
        vec(SEL_B, 1'b0, IN_RD,   O_SW,     "ta_switch3", 1);
        vec(SEL_B, 1'b0, IN_RD,   O_RD,     "ta_first_put", 1);
        vec(SEL_B, 1'b0, IN_NONE, O_RDSTOP, "ta_rxf_stop", 1);
        vec(SEL_B, 1'b0, IN_NONE, O_IDLE,   "ta_end_idle", 1);

        repeat (2) @(posedge ft_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ft_bus_scheduler
